// File: rtl/ni_flit_tx_if.sv
// FIFO read port and router flit port of the NI transmit path, bundled as one interface.
// master = ni_flit_tx side, slave = FIFO/router (or testbench) side.
interface ni_flit_tx_if #(
    parameter int DATA_W = 32
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read_en;
    logic [DATA_W-1:0] flit_data;
    logic [1:0]        flit_type;
    logic              flit_valid;
    logic              flit_ready;

    modport master (
        input  fifo_empty, fifo_data, flit_ready,
        output fifo_read_en, flit_data, flit_type, flit_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flit_ready,
        input  fifo_read_en, flit_data, flit_type, flit_valid
    );
endinterface

// File: rtl/ni_flit_tx.sv
// NI transmit framer: pops FIFO words, parses header length, emits typed flits to the router.
// Optional NI_TX_PKTCNT_EN adds a wrapping 16-bit count of completed packets on pkt_count.
module ni_flit_tx #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         reset,
    ni_flit_tx_if.master bus,
    output logic         busy,
`ifdef NI_TX_PKTCNT_EN
    output logic [15:0]  pkt_count,
`endif
    output logic         error
);
    localparam int            LEN_LSB   = 16;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    typedef enum logic {S_IDLE, S_BODY} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        type_q, type_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [LEN_W-1:0]  hdr_len;
    logic              accept;
    logic              rd_issue;

    // Only one read in flight, and only when the output slot is free or draining this cycle.
    assign rd_issue = !reset && !bus.fifo_empty && !pend_q && (!valid_q || bus.flit_ready);
    assign accept   = valid_q && bus.flit_ready;
    assign hdr_len  = bus.fifo_data[LEN_LSB +: LEN_W];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pend_d  = rd_issue;
        data_d  = data_q;
        type_d  = type_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        error_d = error_q;

        if (accept && type_q == FT_TAIL) begin
            busy_d = 1'b0;
        end

        if (pend_q) begin
            data_d  = bus.fifo_data;
            valid_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (hdr_len == '0) begin
                        type_d = FT_HT;
                    end else begin
                        type_d  = FT_HEAD;
                        rem_d   = (hdr_len > MAX_LEN_L) ? MAX_LEN_L : hdr_len;
                        state_d = S_BODY;
                        busy_d  = 1'b1;
                        if (hdr_len > MAX_LEN_L) begin
                            error_d = 1'b1;
                        end
                    end
                end
                S_BODY: begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        type_d  = FT_TAIL;
                        state_d = S_IDLE;
                    end else begin
                        type_d = FT_BODY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            type_q  <= FT_BODY;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            type_q  <= type_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign bus.fifo_read_en = rd_issue;
    assign bus.flit_data    = data_q;
    assign bus.flit_type    = type_q;
    assign bus.flit_valid   = valid_q;
    assign busy             = busy_q;
    assign error            = error_q;

`ifdef NI_TX_PKTCNT_EN
    logic [15:0] pkt_count_q;

    // Both tail (10) and head+tail (11) close a packet; bit 1 marks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (accept && type_q[1]) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif
endmodule

// File: doc/ni_flit_tx.md
Name: ni_flit_tx

Overview:
- Drain side of the NI packet FIFO (gp_fifo).
- Pops 32-bit words from the FIFO, parses packet framing from each header word, and presents typed flits to the router input port over a valid/ready handshake.
- Sits between the NI FIFO read port and the router local input.
- Mirror of the NI write path: the writer pushes words, this block reads and frames them.

Parameters:
- DATA_W, 32, FIFO word and flit payload width.
- LEN_W, 8, width of the header length field.
- MAX_LEN, 16, maximum body words per packet; larger header values are clamped.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_read_en is asserted while !fifo_empty.
- fifo_read_en  out  1  FIFO pop strobe.
- flit_data  out  DATA_W  flit payload.
- flit_type  out  2  flit type: 01 head, 00 body, 10 tail, 11 head+tail.
- flit_valid  out  1  flit_data and flit_type are valid.
- flit_ready  in  1  router accepts the flit.
- busy  out  1  high while a packet is in progress (head sent, tail not yet sent).
- error  out  1  sticky; set on header length > MAX_LEN.

Behaviour:
- Reset (synchronous): fifo_read_en=0, flit_valid=0, flit_data=0, flit_type=00, busy=0, error=0, state=IDLE, rem=0, pend=0.
- Header format:
  - [31:24] dest.
  - [23:16] len = number of body words that follow.
  - [15:0] user.
  - The whole header word is forwarded unchanged as the head flit.
- Read issue (combinational): fifo_read_en = !fifo_empty && !pend && (!flit_valid || flit_ready).
- pend is set on the cycle after issue; the returned fifo_data is loaded into the output register on that cycle. At most one outstanding read; peak throughput is 1 flit per 2 cycles.
- Output register:
  - Loaded when pend=1.
  - Cleared (flit_valid=0) on flit_valid && flit_ready with no load in the same cycle.
  - Held stable while flit_valid && !flit_ready.
- FSM on each load:
  - IDLE: word is a header.
    - len==0: type=11, stay IDLE, busy stays 0.
    - Otherwise: type=01, rem=min(len,MAX_LEN), go BODY, busy=1.
    - len>MAX_LEN: error<=1.
  - BODY: rem decrements per load.
    - rem>1: type=00.
    - rem==1: type=10, go IDLE, busy<=0 when the tail handshake completes.
- FIFO empty mid-packet: stall. No bubble flit, no error; resume when non-empty.
- Back-pressure: flit_ready=0 holds the output register and blocks new reads. No FIFO word is lost or duplicated.
- Reset mid-packet: all state is cleared and an in-flight read is discarded. The FIFO shares the reset, so no stale data remains.
- Clamped packets: words beyond MAX_LEN are parsed as the next header. error flags this condition and software must reset.

Optional Feature:
- NI_TX_PKTCNT_EN
  - Defined: adds output pkt_count[15:0], reset 0, incremented on each completed tail or head+tail handshake, wraps at 0xFFFF->0.
  - Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Push 0x0101A5A5, 0x0000BBBB, 0x00010001 with flit_ready=1 -> flits (01,0x0101A5A5), (10,0x0000BBBB), (11,0x00010001); busy high from the first flit through the tail handshake; error=0.
- Header 0x0103000F plus 3 body words, flit_ready low for 4 cycles after the head -> flit_data and flit_type held, fifo_read_en=0 during the stall; types 01,00,00,10 delivered in order.
- Header len=2, first body word, FIFO empty 5 cycles, second body word -> flit_valid=0 during the gap, no extra flits, last flit type 10.
- Header 0x0114xxxx (len 20) with MAX_LEN=16 -> error=1, 16 body flits, the 16th typed 10; error remains set.
- Reset asserted mid-BODY with a pending read -> next cycle all outputs at reset values; after new pushes, the first flit is treated as a header.
- With NI_TX_PKTCNT_EN, 3 packets sent -> pkt_count=3. Preload near 0xFFFF and send 2 packets -> pkt_count wraps to 0x0000 then 0x0001.
